// File: rtl/booth_sched_pkg.sv
// Shared types and constants for the Booth multiplier scheduler.
// Optional build macro: BOOTH_SCHED_CHECK_EN (product self-check).
package booth_sched_pkg;

    localparam int OPW       = 4;
    localparam int PW        = 8;
    localparam int STEPS_DEF = 4;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;

    // Exact 8-bit two's complement product of two 4-bit signed operands.
    function automatic logic [PW-1:0] smul(input logic [OPW-1:0] m, input logic [OPW-1:0] q);
        logic signed [PW-1:0] a, b;
        a = signed'({{(PW-OPW){m[OPW-1]}}, m});
        b = signed'({{(PW-OPW){q[OPW-1]}}, q});
        return a * b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request strictly after ptr wins.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Round-robin scheduler time-sharing one radix-2 Booth multiplier among NUM_REQ requesters.
// Optional build macro: BOOTH_SCHED_CHECK_EN adds a sticky product mismatch checker.
module booth_mul_scheduler
    import booth_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int STEPS   = STEPS_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [OPW*NUM_REQ-1:0] req_m,
    input  logic [OPW*NUM_REQ-1:0] req_q,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [PW-1:0]          resp_p,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count,
    output logic                   err_mismatch,
    output logic                   mul_reset,
    output logic                   mul_load,
    output logic [OPW-1:0]         mul_m,
    output logic [OPW-1:0]         mul_q,
    input  logic [PW-1:0]          mul_p
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SC_W  = $clog2(STEPS + 1);

    state_t                       state;
    logic [IDX_W-1:0]             ptr, idx_r, gnt_idx;
    logic [NUM_REQ-1:0]           gnt;
    logic [SC_W-1:0]              step_cnt;
    logic [NUM_REQ-1:0][OPW-1:0]  m_arr, q_arr;
    logic                         accept;

    assign m_arr = req_m;
    assign q_arr = req_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign req_ready = (state == IDLE) ? gnt : '0;
    assign accept    = |req_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NUM_REQ - 1);
            idx_r      <= '0;
            step_cnt   <= '0;
            mul_reset  <= 1'b1;
            mul_load   <= 1'b0;
            mul_m      <= '0;
            mul_q      <= '0;
            resp_valid <= '0;
            resp_p     <= '0;
            op_count   <= '0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: if (accept) begin
                    idx_r     <= gnt_idx;
                    ptr       <= gnt_idx;
                    mul_m     <= m_arr[gnt_idx];
                    mul_q     <= q_arr[gnt_idx];
                    mul_reset <= 1'b0;
                    mul_load  <= 1'b1;
                    state     <= LOAD;
                end
                LOAD: begin
                    mul_load <= 1'b0;
                    step_cnt <= SC_W'(STEPS);
                    state    <= RUN;
                end
                RUN: begin
                    step_cnt <= step_cnt - SC_W'(1);
                    if (step_cnt == SC_W'(1)) state <= CAPT;
                end
                CAPT: begin
                    // mul_p settled after the last Booth step; hand it back and re-clear the multiplier
                    resp_p            <= mul_p;
                    resp_valid[idx_r] <= 1'b1;
                    op_count          <= op_count + CNT_W'(1);
                    mul_reset         <= 1'b1;
                    mul_m             <= '0;
                    mul_q             <= '0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BOOTH_SCHED_CHECK_EN
    logic [PW-1:0] exp_p;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_p        <= '0;
            err_mismatch <= 1'b0;
        end else begin
            if (accept) exp_p <= smul(m_arr[gnt_idx], q_arr[gnt_idx]);
            if (state == CAPT && mul_p != exp_p) err_mismatch <= 1'b1;
        end
    end
`else
    assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Self-checking bench for booth_mul_scheduler with a behavioural Booth multiplier attached.
module tb_booth_mul_scheduler;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MASK = (1 << TB_CNT_W) - 1;

    logic        clk, reset_n;
    logic [3:0]  req_valid, req_ready, resp_valid;
    logic [15:0] req_m, req_q;
    logic [7:0]  resp_p, mul_p;
    logic        busy, err_mismatch, mul_reset, mul_load;
    logic [TB_CNT_W-1:0] op_count;
    logic [3:0]  mul_m, mul_q;

    int n_chk = 0, n_fail = 0;
    int last_gnt = 3, exp_cnt = 0;
    bit err_exp = 1'b0;

    booth_mul_scheduler #(.NUM_REQ(4), .STEPS(4), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_m(req_m), .req_q(req_q),
        .resp_valid(resp_valid), .resp_p(resp_p),
        .busy(busy), .op_count(op_count), .err_mismatch(err_mismatch),
        .mul_reset(mul_reset), .mul_load(mul_load),
        .mul_m(mul_m), .mul_q(mul_q), .mul_p(mul_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier environment: state {A,Q,q-1}, stops after 4 steps, has no done flag.
    logic [8:0] bs;
    int         bcnt;

    function automatic logic [8:0] booth_step(input logic [8:0] s, input logic [3:0] m);
        logic [3:0] a;
        a = s[8:5];
        case (s[1:0])
            2'b10:   a = a - m;
            2'b01:   a = a + m;
            default: ;
        endcase
        return {a[3], a, s[4:1]};
    endfunction

    always @(posedge clk) begin
        if (mul_reset) begin
            bs <= '0; bcnt <= 4;
        end else if (mul_load) begin
            bs <= {4'b0, mul_q, 1'b0}; bcnt <= 0;
        end else if (bcnt < 4) begin
            bs <= booth_step(bs, mul_m); bcnt <= bcnt + 1;
        end
    end
    assign mul_p = bs[8:1];

    function automatic logic [7:0] smul(input logic [3:0] m, input logic [3:0] q);
        return 8'(int'($signed(m)) * int'($signed(q)));
    endfunction

    function automatic int exp_grant(input logic [3:0] mask);
        for (int k = 1; k <= 4; k++)
            if (mask[(last_gnt + k) % 4]) return (last_gnt + k) % 4;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation; caller is in an IDLE cycle, 1 time unit after the edge.
    task automatic run_op(input logic [3:0] mask, input logic [15:0] ms, input logic [15:0] qs,
                          input bit has_exp, input logic [7:0] exp_in);
        int g;
        logic [3:0] m, q;
        logic [7:0] exp;
        g = exp_grant(mask);
        m = ms[g*4 +: 4];
        q = qs[g*4 +: 4];
        exp = has_exp ? exp_in : smul(m, q);
        req_m = ms; req_q = qs; req_valid = mask;
        #1;
        chk("grant", 32'(req_ready), 32'(1) << g);
        @(posedge clk); #1;
        req_valid = '0;
        chk("load_ctl", {29'd0, mul_load, mul_reset, busy}, 32'b101);
        chk("load_ops", 32'({mul_m, mul_q}), 32'({m, q}));
        chk("ready_busy", 32'(req_ready), 32'd0);
        for (int c = 2; c <= 6; c++) begin
            @(posedge clk); #1;
            chk("no_early_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        last_gnt = g;
        exp_cnt++;
`ifdef BOOTH_SCHED_CHECK_EN
        if (exp != smul(m, q)) err_exp = 1'b1;
`endif
        chk("resp_valid", 32'(resp_valid), 32'(1) << g);
        chk("resp_p", 32'(resp_p), 32'(exp));
        chk("op_count", 32'(op_count), 32'(exp_cnt & CNT_MASK));
        chk("err_mismatch", 32'(err_mismatch), 32'(err_exp));
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic rand_ops(input int n);
        logic [15:0] ms, qs;
        for (int i = 0; i < n; i++) begin
            ms = 16'($urandom);
            qs = 16'($urandom);
            for (int s = 0; s < 4; s++)
                if (ms[s*4 +: 4] == 4'h8) ms[s*4 +: 4] = 4'h7;
            run_op(4'($urandom_range(1, 15)), ms, qs, 1'b0, 8'h00);
        end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = '0; req_m = '0; req_q = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mul_ctl", {29'd0, mul_reset, mul_load, busy}, 32'b100);
        chk("rst_mul_ops", 32'({mul_m, mul_q}), 32'd0);
        chk("rst_resp", 32'({resp_valid, resp_p}), 32'd0);
        chk("rst_cnt_err", 32'({op_count, err_mismatch}), 32'd0);
        reset_n = 1'b1;

        run_op(4'b0001, 16'h0003, 16'h0002, 1'b1, 8'h06);
        run_op(4'b0010, 16'h00D0, 16'h0050, 1'b1, 8'hF1);
        run_op(4'b0100, 16'h0E00, 16'h0900, 1'b1, 8'h0E);
        for (int i = 0; i < 5; i++)
            run_op(4'b1111, 16'h5A3C, 16'h7E21, 1'b0, 8'h00);
        // M=-8 overflows the 4-bit accumulator: Booth yields 8'h08, not 8'hF8
        run_op(4'b0001, 16'h0008, 16'h0001, 1'b1, 8'h08);
        rand_ops(3);

        req_m = 16'h0005; req_q = 16'h0003; req_valid = 4'b0001;
        #1;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("abort_mul_ctl", {29'd0, mul_reset, mul_load, busy}, 32'b100);
        chk("abort_resp", 32'({resp_valid, resp_p}), 32'd0);
        chk("abort_cnt_err", 32'({op_count, err_mismatch}), 32'd0);
        @(posedge clk); #1;
        chk("abort_no_resp", 32'(resp_valid), 32'd0);
        reset_n = 1'b1;
        last_gnt = 3; exp_cnt = 0; err_exp = 1'b0;

        run_op(4'b0001, 16'h0005, 16'h0003, 1'b1, 8'h0F);
        rand_ops(17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
